// File: rtl/stage1_arb.sv
// stage1_arb: round-robin front end for one shared stage1 datapath.
//
// N_REQ requesters compete for a single datapath input (dp_A). The winner's
// target is registered onto dp_A; a {valid, id} tag follows it through a
// LAT-deep shadow pipeline, so the datapath results (dp_C/dp_Csgn/dp_nxttgt)
// can be captured, labelled and queued in a result FIFO. A credit counter
// sized to the FIFO stops grants before anything in flight could overflow it.
//
// Ports
//   clk                  rising-edge clock
//   rst_n                synchronous reset, ACTIVE HIGH despite the name
//   enable               permits new grants
//   req_valid[N_REQ]     per-requester sample valid
//   req_data[32*N_REQ]   per-requester target, slice i = [32i+31:32i]
//   req_ready[N_REQ]     one-hot grant (combinational)
//   dp_A[32]             registered target to the datapath
//   dp_C/dp_Csgn/dp_nxttgt  datapath results, LAT clocks after dp_A
//   res_valid/res_ready  result handshake
//   res_id/res_C/res_Csgn/res_nxttgt  FIFO head payload
//   busy                 any sample in flight or any result queued
module stage1_arb #(
  parameter int N_REQ      = 4,
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [32*N_REQ-1:0]        req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [31:0]                dp_A,
  input  logic [15:0]                dp_C,
  input  logic                       dp_Csgn,
  input  logic [31:0]                dp_nxttgt,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(N_REQ)-1:0]   res_id,
  output logic [15:0]                res_C,
  output logic                       res_Csgn,
  output logic [31:0]                res_nxttgt,
  output logic                       busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int EW  = IDW + 16 + 1 + 32;

  // arbitration state
  logic [IDW-1:0]   r_last;
  logic [CW-1:0]    r_credit;
  logic [N_REQ-1:0] w_grant;
  logic [IDW-1:0]   w_gnt_id;
  logic [IDW-1:0]   w_idx;
  logic             w_found;
  logic             w_can_grant;
  logic             w_acc;

  // dp_A stage and tag pipeline
  logic             r_a_vld;
  logic [IDW-1:0]   r_a_id;
  logic [31:0]      r_dp_A;
  logic [LAT-1:0]   r_tag_vld;
  logic [IDW-1:0]   r_tag_id [LAT];

  // result FIFO
  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [PW:0]      r_wp;
  logic [PW:0]      r_rp;
  logic             w_empty;
  logic             w_wr;
  logic             w_pop;
  logic [EW-1:0]    w_wdata;
  logic [EW-1:0]    w_head;

  // ---------------------------------------------------------------------------
  // Round-robin grant: scan from (r_last+1) mod N_REQ, first valid wins.
  // ---------------------------------------------------------------------------
  assign w_can_grant = enable && !rst_n && (r_credit != '0);

  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = IDW'((32'(r_last) + 32'd1 + k) % N_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
    if (w_found && w_can_grant) begin
      w_grant[w_gnt_id] = 1'b1;
    end
  end

  assign req_ready = w_grant;
  // A grant only ever goes to a valid requester, so any grant is an acceptance.
  assign w_acc     = |(req_valid & w_grant);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_last  <= IDW'(N_REQ - 1);
      r_a_vld <= 1'b0;
      r_a_id  <= '0;
      r_dp_A  <= '0;
    end else begin
      r_a_vld <= w_acc;
      if (w_acc) begin
        r_last <= w_gnt_id;
        r_a_id <= w_gnt_id;
        r_dp_A <= req_data[32*w_gnt_id +: 32];
      end
    end
  end

  assign dp_A = r_dp_A;

  // ---------------------------------------------------------------------------
  // Tag pipeline: entry LAT-1 lines up with the datapath result for the
  // dp_A value presented LAT clocks earlier.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_tag_vld <= '0;
      for (int unsigned k = 0; k < LAT; k++) begin
        r_tag_id[k] <= '0;
      end
    end else begin
      r_tag_vld[0] <= r_a_vld;
      r_tag_id[0]  <= r_a_id;
      for (int unsigned k = 1; k < LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO. The credit counter guarantees a free slot for every tagged
  // sample, so the write side needs no full check.
  // ---------------------------------------------------------------------------
  assign w_wr    = r_tag_vld[LAT-1];
  assign w_wdata = {r_tag_id[LAT-1], dp_C, dp_Csgn, dp_nxttgt};
  assign w_empty = (r_wp == r_rp);
  assign w_pop   = res_valid && res_ready;
  assign w_head  = r_mem[r_rp[PW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr && !rst_n) begin
      r_mem[r_wp[PW-1:0]] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) begin
        r_wp <= r_wp + (PW+1)'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + (PW+1)'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Credits: one per FIFO slot, held from acceptance until the result pops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_credit <= CW'(FIFO_DEPTH);
    end else if (w_acc && !w_pop) begin
      r_credit <= r_credit - CW'(1);
    end else if (!w_acc && w_pop) begin
      r_credit <= r_credit + CW'(1);
    end
  end

  // Outputs are forced quiet during reset; payload is zero whenever no
  // result is offered.
  assign res_valid = !rst_n && !w_empty;
  assign {res_id, res_C, res_Csgn, res_nxttgt} = res_valid ? w_head : '0;
  assign busy = !rst_n && ((|r_tag_vld) || r_a_vld || !w_empty);

endmodule
